// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Frame layout: LEN_LO, LEN_HI, then N little-endian 3-byte words.
package imem_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    B0,
    B1,
    B2,
    WRITE,
    CSUM,
    DONE,
    ERR
  } loader_state_e;

  localparam int WORD_W_DEF = 19;
  localparam int BPW        = (WORD_W_DEF + 7) / 8;

  // Bits of the top byte that lie above WORD_W and must be zero.
  localparam logic [7:0] B2_PAD_MASK = 8'(8'hFF << (WORD_W_DEF - 8 * (BPW - 1)));

  function automatic logic is_ready_state(input loader_state_e s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == B0) ||
           (s == B1) || (s == B2) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// Shifts in BPW little-endian bytes and presents the WORD_W-bit word.
// ovf flags nonzero bits in the padding region of the top byte.
module byte_word_assembler
  import imem_loader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              ovf
);

  logic [8*BPW-1:0] sr;

  // New bytes enter at the top, so after BPW shifts the first byte sits in bits [7:0].
  always_ff @(posedge clk) begin
    if (rst || clr) sr <= '0;
    else if (shift) sr <= {byte_in, sr[8*BPW-1:8]};
  end

  assign word = sr[WORD_W-1:0];
  assign ovf  = |sr[8*BPW-1:WORD_W];

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the
// core in reset until a load succeeds. Define IMEM_LOADER_CHECKSUM_EN to add
// a trailing XOR checksum byte to the frame.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int MAX_WORDS = 2 ** ADDR_W;

  loader_state_e state, state_nxt;

  logic [7:0]        len_lo;
  logic [12:0]       n_words;
  logic [12:0]       n_hdr;
  logic [ADDR_W-1:0] cnt;
  logic              xfer;
  logic              start_ok;
  logic              last_word;
  logic              shift;
  logic [WORD_W-1:0] word;
  logic              ovf;

  assign byte_ready = is_ready_state(state);
  assign xfer       = byte_valid && byte_ready;
  assign start_ok   = start && !abort &&
                      ((state == IDLE) || (state == DONE) || (state == ERR));
  assign n_hdr      = {byte_data[4:0], len_lo};
  assign last_word  = (32'(cnt) == 32'(n_words) - 32'd1);
  assign shift      = xfer && ((state == B0) || (state == B1) || (state == B2));

  byte_word_assembler #(.WORD_W(WORD_W)) u_asm (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_ok || abort),
    .shift   (shift),
    .byte_in (byte_data),
    .word    (word),
    .ovf     (ovf)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] acc;

  always_ff @(posedge clk) begin
    if (rst || start_ok) acc <= '0;
    else if (xfer && (state != CSUM)) acc <= acc ^ byte_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start) state_nxt = LEN_LO;
        LEN_LO: if (xfer) state_nxt = LEN_HI;
        LEN_HI: begin
          if (xfer) begin
            if ((byte_data[7:5] != 3'd0) || (32'(n_hdr) > MAX_WORDS))
              state_nxt = ERR;
            else if (n_hdr == 13'd0)
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_nxt = CSUM;
`else
              state_nxt = DONE;
`endif
            else
              state_nxt = B0;
          end
        end
        B0: if (xfer) state_nxt = B1;
        B1: if (xfer) state_nxt = B2;
        B2: if (xfer) state_nxt = WRITE;
        WRITE: begin
          // A padded top byte with stray bits kills the load without writing.
          if (ovf)
            state_nxt = ERR;
          else if (last_word)
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = DONE;
`endif
          else
            state_nxt = B0;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: if (xfer) state_nxt = (byte_data == acc) ? DONE : ERR;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo  <= '0;
      n_words <= '0;
      cnt     <= '0;
    end else if (abort || start_ok) begin
      cnt <= '0;
    end else begin
      if (xfer && (state == LEN_LO)) len_lo <= byte_data;
      if (xfer && (state == LEN_HI)) begin
        n_words <= n_hdr;
        cnt     <= '0;
      end
      // Stops at N-1, so N == MAX_WORDS never wraps the counter.
      if ((state == WRITE) && !ovf && !last_word) cnt <= cnt + 1'b1;
    end
  end

  assign im_we    = (state == WRITE) && !ovf;
  assign im_addr  = cnt;
  assign im_wdata = word;
  assign cpu_hold = (state != DONE);
  assign done     = (state == DONE);
  assign error    = (state == ERR);

endmodule
